// File: rtl/wseq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wseq_pkg
// Description : State typedef, encodings and next-state function for the
//               wseq sequence-detector FSM bank.
// Revision    : 1.0 - initial release
// ============================================================================
package wseq_pkg;

    typedef enum logic [2:0] {
        ST_A = 3'b000,
        ST_B = 3'b001,
        ST_C = 3'b010,
        ST_D = 3'b011,
        ST_E = 3'b100,
        ST_F = 3'b101
    } wseq_state_e;

    localparam logic [2:0] C_ST_A = 3'b000;
    localparam logic [2:0] C_ST_B = 3'b001;
    localparam logic [2:0] C_ST_C = 3'b010;
    localparam logic [2:0] C_ST_D = 3'b011;
    localparam logic [2:0] C_ST_E = 3'b100;
    localparam logic [2:0] C_ST_F = 3'b101;

    // Unused codes 110/111 fall back to A.
    function automatic logic [2:0] wseq_next(input logic [2:0] s, input logic w);
        logic [2:0] n;
        case (s)
            C_ST_A:  n = w ? C_ST_A : C_ST_B;
            C_ST_B:  n = w ? C_ST_D : C_ST_C;
            C_ST_C:  n = w ? C_ST_D : C_ST_E;
            C_ST_D:  n = w ? C_ST_A : C_ST_F;
            C_ST_E:  n = w ? C_ST_D : C_ST_E;
            C_ST_F:  n = w ? C_ST_D : C_ST_C;
            default: n = C_ST_A;
        endcase
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wseq_fsm_ch.sv
`default_nettype none
// ============================================================================
// Module      : wseq_fsm_ch
// Description : One FSM channel: state register, Moore z decode and an
//               optional saturating hit counter (built when WSEQ_HITCNT_EN
//               is defined).
// Revision    : 1.0 - initial release
// ============================================================================
module wseq_fsm_ch
    import wseq_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_w,
    input  logic             i_clr,
    output logic [2:0]       o_state,
    output logic             o_z,
    output logic [CNT_W-1:0] o_hit_cnt
);

    logic [2:0] r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= C_ST_A;
        end else if (i_en) begin
            r_state <= wseq_next(r_state, i_w);
        end
    end

    assign o_state = r_state;
    assign o_z     = (r_state == C_ST_E) || (r_state == C_ST_F);

`ifdef WSEQ_HITCNT_EN
    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    logic             w_hit;
    logic [CNT_W-1:0] r_hit_cnt;

    assign w_hit = i_en && (r_state == C_ST_D) && !i_w;

    // Clear has priority over a coincident hit; count saturates.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_hit_cnt <= '0;
        end else if (w_hit && (r_hit_cnt != C_CNT_MAX)) begin
            r_hit_cnt <= r_hit_cnt + CNT_W'(1);
        end
    end

    assign o_hit_cnt = r_hit_cnt;
`else
    logic w_unused_clr;

    assign w_unused_clr = i_clr;
    assign o_hit_cnt    = '0;
`endif

endmodule
`default_nettype wire

// File: rtl/wseq_fsm_bank.sv
`default_nettype none
// ============================================================================
// Module      : wseq_fsm_bank
// Description : Bank of NCH independent wseq FSM channels. Hit counters are
//               built only when macro WSEQ_HITCNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module wseq_fsm_bank
    import wseq_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH-1:0]       en,
    input  logic [NCH-1:0]       w,
    input  logic [NCH-1:0]       clr,
    output logic [3*NCH-1:0]     state_o,
    output logic [NCH-1:0]       z,
    output logic [CNT_W*NCH-1:0] hit_cnt
);

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_ch
            wseq_fsm_ch #(
                .CNT_W (CNT_W)
            ) u_ch (
                .clk       (clk),
                .rst       (reset),
                .i_en      (en[i]),
                .i_w       (w[i]),
                .i_clr     (clr[i]),
                .o_state   (state_o[3*i +: 3]),
                .o_z       (z[i]),
                .o_hit_cnt (hit_cnt[CNT_W*i +: CNT_W])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_wseq_fsm_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_wseq_fsm_bank
// Description : Directed self-checking bench for wseq_fsm_bank.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wseq_fsm_bank;

    localparam int NCH   = 4;
    localparam int CNT_W = 8;

    localparam logic [2:0] SA = 3'b000;
    localparam logic [2:0] SB = 3'b001;
    localparam logic [2:0] SC = 3'b010;
    localparam logic [2:0] SD = 3'b011;
    localparam logic [2:0] SE = 3'b100;
    localparam logic [2:0] SF = 3'b101;

    logic                 clk;
    logic                 reset;
    logic [NCH-1:0]       en;
    logic [NCH-1:0]       w;
    logic [NCH-1:0]       clr;
    logic [3*NCH-1:0]     state_o;
    logic [NCH-1:0]       z;
    logic [CNT_W*NCH-1:0] hit_cnt;

    int n_checks;
    int n_fails;

    wseq_fsm_bank #(
        .NCH   (NCH),
        .CNT_W (CNT_W)
    ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .w       (w),
        .clr     (clr),
        .state_o (state_o),
        .z       (z),
        .hit_cnt (hit_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fails++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Expected counter value: zero when the counters are not built.
    function automatic logic [31:0] eh(input int n);
`ifdef WSEQ_HITCNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    function automatic logic [31:0] st(input int ch);
        return {29'd0, state_o[3*ch +: 3]};
    endfunction

    function automatic logic [31:0] hc(input int ch);
        return {24'd0, hit_cnt[CNT_W*ch +: CNT_W]};
    endfunction

    task automatic step(input logic [NCH-1:0] e, input logic [NCH-1:0] ww, input logic [NCH-1:0] c);
        en  = e;
        w   = ww;
        clr = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset = 1'b1;
        en    = '1;
        w     = 4'b0101;
        clr   = '0;
        @(posedge clk);
        #1;
        step(4'hF, 4'h0, 4'h0);
        check_val("rst_state", {20'd0, state_o}, 32'd0);
        check_val("rst_z", {28'd0, z}, 32'd0);
        check_val("rst_hit", hit_cnt, 32'd0);
        reset = 1'b0;

        // Channel 0: w=0,0,0 -> B, C, E
        step(4'h1, 4'h0, 4'h0);
        check_val("c0_B", st(0), SB);
        check_val("c0_B_z", {31'd0, z[0]}, 32'd0);
        step(4'h1, 4'h0, 4'h0);
        check_val("c0_C", st(0), SC);
        step(4'h1, 4'h0, 4'h0);
        check_val("c0_E", st(0), SE);
        check_val("c0_E_z", {31'd0, z[0]}, 32'd1);

        // From A: w=0,1,0 -> B, D, F with one hit
        reset = 1'b1;
        step(4'h0, 4'h0, 4'h0);
        reset = 1'b0;
        check_val("c0_A_again", st(0), SA);
        step(4'h1, 4'h0, 4'h0);
        check_val("c0_B2", st(0), SB);
        check_val("c0_B2_hit", hc(0), 32'd0);
        step(4'h1, 4'h1, 4'h0);
        check_val("c0_D", st(0), SD);
        check_val("c0_D_z", {31'd0, z[0]}, 32'd0);
        step(4'h1, 4'h0, 4'h0);
        check_val("c0_F", st(0), SF);
        check_val("c0_F_z", {31'd0, z[0]}, 32'd1);
        check_val("c0_F_hit", hc(0), eh(1));

        // F -> D, then D->F->D 300 times: 301 hits saturate at 255
        step(4'h1, 4'h1, 4'h0);
        check_val("c0_loop_D", st(0), SD);
        for (int k = 0; k < 300; k++) begin
            step(4'h1, 4'h0, 4'h0);
            if (k == 252) check_val("c0_hit_254", hc(0), eh(254));
            step(4'h1, 4'h1, 4'h0);
        end
        check_val("c0_sat_state", st(0), SD);
        check_val("c0_sat_hit", hc(0), eh(255));

        // clr together with a hit: clr wins, state still advances
        step(4'h1, 4'h0, 4'h1);
        check_val("c0_clr_hit", hc(0), 32'd0);
        check_val("c0_clr_state", st(0), SF);

        // Channel 1 to E while channel 0 holds
        step(4'h2, 4'h0, 4'h0);
        step(4'h2, 4'h0, 4'h0);
        step(4'h2, 4'h0, 4'h0);
        check_val("c1_E", st(1), SE);
        check_val("c0_held", st(0), SF);

        // Channel 1 disabled, w toggles; channel 0 steps F->D->F->D->F->D
        for (int k = 0; k < 5; k++) begin
            step(4'h1, (k % 2 == 0) ? 4'hF : 4'h0, 4'h0);
            check_val("c1_hold_E", st(1), SE);
            check_val("c0_run", st(0), (k % 2 == 0) ? SD : SF);
        end
        check_val("c0_run_hit", hc(0), eh(2));
        check_val("c1_hit_zero", hc(1), 32'd0);

        // Channel 2 to F with three hits: B, D, F, D, F, D, F
        step(4'h4, 4'h0, 4'h0);
        step(4'h4, 4'h4, 4'h0);
        step(4'h4, 4'h0, 4'h0);
        step(4'h4, 4'h4, 4'h0);
        step(4'h4, 4'h0, 4'h0);
        step(4'h4, 4'h4, 4'h0);
        step(4'h4, 4'h0, 4'h0);
        check_val("c2_F", st(2), SF);
        check_val("c2_hit3", hc(2), eh(3));
        check_val("c3_idle", st(3), SA);

        // Mid-sequence reset overrides en/w/clr
        reset = 1'b1;
        step(4'hF, 4'h5, 4'h0);
        check_val("rst2_state", {20'd0, state_o}, 32'd0);
        check_val("rst2_z", {28'd0, z}, 32'd0);
        check_val("rst2_hit", hit_cnt, 32'd0);
        reset = 1'b0;
        step(4'h1, 4'h0, 4'h0);
        check_val("resume_B", st(0), SB);
        check_val("resume_c2_A", st(2), SA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wseq_fsm_bank.md
WSEQ_FSM_BANK -- requirements
Module: wseq_fsm_bank

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning number of independent FSM channels (1..32).
REQ-002 SHALL have parameter CNT_W, default 8, meaning width of each per-channel hit counter (2..16).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port en  input  NCH  per-channel step enable.
REQ-006 SHALL have port w  input  NCH  per-channel FSM input bit.
REQ-007 SHALL have port clr  input  NCH  per-channel hit-counter clear.
REQ-008 SHALL have port state_o  output  3*NCH  per-channel current state code; channel i occupies bits [3i+2:3i].
REQ-009 SHALL have port z  output  NCH  per-channel Moore output.
REQ-010 SHALL have port hit_cnt  output  CNT_W*NCH  per-channel hit count; channel i occupies bits [CNT_W*i+CNT_W-1:CNT_W*i].

Function
REQ-011 Each channel SHALL hold a registered 3-bit state with the codes A=000, B=001, C=010, D=011, E=100 and F=101.
REQ-012 With en[i]=1, channel i SHALL take the next state on the clock edge from its current state and w[i] (w=0 / w=1):
- A: B / A
- B: C / D
- C: E / D
- D: F / A
- E: E / D
- F: C / D
REQ-013 Codes 110 and 111 SHALL go to A on the next enabled edge.
REQ-014 With en[i]=0, channel i state SHALL hold and its counter SHALL not increment.
REQ-015 z[i] SHALL be 1 exactly when the state of channel i is E or F.
- z is decoded from the state register, so it has no additional latency beyond the state update.
REQ-016 A hit SHALL be an enabled edge where channel i moves D->F (w[i]=0 in D).
REQ-017 Each hit SHALL increment hit_cnt[i] by 1, and the counter SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-018 clr[i]=1 SHALL set hit_cnt[i] to 0 on the next edge; clr wins over a simultaneous hit, and clr does not affect state.
REQ-019 Channels SHALL be fully independent: no en, w or clr bit of one channel affects another channel.

Reset
REQ-020 On reset=1 at a clock edge, every channel SHALL go to state A, so z=0 and state_o=0.
REQ-021 On reset=1 at a clock edge, every hit_cnt SHALL go to 0.
REQ-022 reset SHALL override en, w and clr, including when asserted mid-sequence.
REQ-023 On the first edge after reset deasserts, normal operation SHALL resume from A.

Configuration
REQ-024 Macro WSEQ_HITCNT_EN SHALL control whether the hit counters are built.
- Defined: the counters and clr behave per REQ-016..018.
- Undefined: no counter flops are built, hit_cnt is tied to 0, and clr is ignored.
- The state machine and z behave identically in both builds.

Structure
REQ-025 Package wseq_pkg SHALL hold the 3-bit state typedef (enum A..F) and the encoding constants.
REQ-026 wseq_fsm_bank SHALL instantiate NCH copies of sub-module wseq_fsm_ch through a generate loop.
- wseq_fsm_ch holds one state register, the z decode and the optional counter.

Verification
REQ-027 Reset, then channel 0 steps with en=1 and w=0,0,0 -> state_o[2:0] = B, then C, then E; z[0]=1 after the third edge.
REQ-028 From A, w=0,1,0 -> states B, D, F; z[0]=1 and hit_cnt[0]=1.
REQ-029 Loop D->F->D via w=0,1 repeated 300 times with CNT_W=8 -> hit_cnt[0] holds at 255.
- Then assert clr[0] together with a hit -> hit_cnt[0]=0.
REQ-030 Drive channel 1 to E, then hold en[1]=0 for 5 cycles while w toggles -> state stays E.
- Channel 0 keeps stepping normally during this time.
REQ-031 Assert reset while channel 2 is in F with hit_cnt=3 -> next edge gives state A, z=0, hit_cnt=0.
REQ-032 Build without WSEQ_HITCNT_EN and rerun REQ-028 -> identical states and z, with hit_cnt=0 throughout.
